upd7800_phase_ctrl: RTL and testbench

//  Sequencer for the uPD7800 core. Divides CLK into the two-phase machine clock and

---
 rtl/upd7800_phase_ctrl_pkg.sv | 19 +
 rtl/upd7800_phase_ctrl.sv | 85 ++++++++
 tb/tb_upd7800_phase_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/upd7800_phase_ctrl_pkg.sv
// uPD7800 phase sequencer: shared phase encoding and sizing helpers.
// Imported by the sequencer top.
package upd7800_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    PH_P1H,
    PH_P1L,
    PH_P2H,
    PH_P2L,
    PH_WAIT,
    PH_HOLD
  } e_phase;

  // bits needed to hold 0..n-1, never less than 1
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/upd7800_phase_ctrl.sv
// uPD7800 two-phase clock sequencer with WAIT stretch, bus HOLD
// and a core reset stretched over a fixed number of cp2n strobes.
module upd7800_phase_ctrl #(
  parameter int DIV        = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESETB,
  input  logic CE,
  input  logic WAITB,
  input  logic HOLD,
  output logic HLDA,
  output logic CP1,
  output logic CP2,
  output logic CP1_POSEDGE,
  output logic CP1_NEGEDGE,
  output logic CP2_POSEDGE,
  output logic CP2_NEGEDGE,
  output logic CPU_RESETB
);
  import upd7800_phase_ctrl_pkg::*;

  localparam int DW = cnt_w(DIV);
  localparam int RW = cnt_w(RST_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  e_phase          state;
  e_phase          nxt;
  logic [DW-1:0]   div_cnt;
  logic [RW-1:0]   rst_cnt;
  logic            term;

  assign term = CE && (div_cnt == DIV_LAST);

  always_comb begin
    nxt = state;
    if (term) begin
      unique case (state)
        PH_P1H:  nxt = PH_P1L;
        PH_P1L:  nxt = WAITB ? PH_P2H : PH_WAIT;
        PH_WAIT: nxt = WAITB ? PH_P2H : PH_WAIT;
        PH_P2H:  nxt = PH_P2L;
        PH_P2L:  nxt = (HOLD && CPU_RESETB) ? PH_HOLD
                                            : PH_P1H;
        PH_HOLD: nxt = HOLD ? PH_HOLD : PH_P1H;
        default: nxt = PH_P2L;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state       <= PH_P2L;
      div_cnt     <= '0;
      rst_cnt     <= '0;
      HLDA        <= 1'b0;
      CP1         <= 1'b0;
      CP2         <= 1'b0;
      CP1_POSEDGE <= 1'b0;
      CP1_NEGEDGE <= 1'b0;
      CP2_POSEDGE <= 1'b0;
      CP2_NEGEDGE <= 1'b0;
      CPU_RESETB  <= 1'b0;
    end else begin
      if (CE)
        div_cnt <= term ? '0 : div_cnt + 1'b1;
      state <= nxt;
      CP1   <= (nxt == PH_P1H);
      CP2   <= (nxt == PH_P2H);
      HLDA  <= (nxt == PH_HOLD);
      // strobes mark entry only; they clear even when CE=0
      CP1_POSEDGE <= (nxt == PH_P1H) && (state != PH_P1H);
      CP1_NEGEDGE <= (nxt == PH_P1L) && (state != PH_P1L);
      CP2_POSEDGE <= (nxt == PH_P2H) && (state != PH_P2H);
      CP2_NEGEDGE <= (nxt == PH_P2L) && (state != PH_P2L);
      if (CP2_NEGEDGE && !CPU_RESETB) begin
        rst_cnt <= rst_cnt + 1'b1;
        if (rst_cnt == RST_LAST)
          CPU_RESETB <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_upd7800_phase_ctrl.sv
// Directed bench for the uPD7800 phase sequencer (DIV=2,
// RST_CYCLES=4): startup, WAIT, HOLD, CE freeze, async abort.
module tb_upd7800_phase_ctrl;

  logic CLK = 1'b0;
  logic RESETB, CE, WAITB, HOLD;
  logic HLDA, CP1, CP2, CPU_RESETB;
  logic CP1_POSEDGE, CP1_NEGEDGE;
  logic CP2_POSEDGE, CP2_NEGEDGE;
  logic [7:0] obs;

  int vecs = 0;
  int errs = 0;
  int t    = 0;

  upd7800_phase_ctrl #(.DIV(2), .RST_CYCLES(4)) dut (
    .CLK         (CLK),
    .RESETB      (RESETB),
    .CE          (CE),
    .WAITB       (WAITB),
    .HOLD        (HOLD),
    .HLDA        (HLDA),
    .CP1         (CP1),
    .CP2         (CP2),
    .CP1_POSEDGE (CP1_POSEDGE),
    .CP1_NEGEDGE (CP1_NEGEDGE),
    .CP2_POSEDGE (CP2_POSEDGE),
    .CP2_NEGEDGE (CP2_NEGEDGE),
    .CPU_RESETB  (CPU_RESETB)
  );

  always #5 CLK = ~CLK;

  assign obs = {HLDA, CPU_RESETB, CP1, CP2,
                CP1_POSEDGE, CP1_NEGEDGE,
                CP2_POSEDGE, CP2_NEGEDGE};

  // {CP1,CP2,p1p,p1n,p2p,p2n} k edges after reset release
  function automatic logic [5:0] exp_norm(input int k);
    logic [5:0] v;
    v = '0;
    if (k >= 2) begin
      case ((k - 2) % 8)
        0: v = 6'b101000;
        1: v = 6'b100000;
        2: v = 6'b000100;
        4: v = 6'b010010;
        5: v = 6'b010000;
        6: v = 6'b000001;
        default: v = 6'b000000;
      endcase
    end
    return v;
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic align(input int m);
    while (((t - 2) % 8) != m) begin
      step();
      t++;
    end
  endtask

  task automatic test_reset;
    RESETB = 1'b0;
    CE     = 1'b1;
    WAITB  = 1'b1;
    HOLD   = 1'b0;
    repeat (3) step();
    vecs++;
    if (obs !== 8'h00) begin
      errs++;
      $display("FAIL reset got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_startup(input logic hold_in);
    int n2n;
    logic [7:0] e;
    n2n    = 0;
    HOLD   = hold_in;
    RESETB = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      e = {1'b0, (k >= 33), exp_norm(k)};
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL startup k=%0d got %b want %b", k, obs, e);
      end
      if (CP2_NEGEDGE && !CPU_RESETB)
        n2n++;
      if (k == 32)
        HOLD = 1'b0;
    end
    vecs++;
    if (n2n !== 4) begin
      errs++;
      $display("FAIL rst_strobes got %0d want 4", n2n);
    end
    t = 40;
  endtask

  task automatic test_wait;
    int k;
    logic [7:0] e;
    align(2);
    k = t;
    WAITB = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step();
      e = (j < 8) ? 8'b0100_0000
                  : {2'b01, exp_norm(k + j - 6)};
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL wait j=%0d got %b want %b", j, obs, e);
      end
      if (j == 7)  WAITB = 1'b1;
      if (j == 8)  WAITB = 1'b0;
      if (j == 12) WAITB = 1'b1;
    end
    t = k + 10;
  endtask

  task automatic test_hold;
    int k;
    logic [7:0] e;
    align(0);
    k = t;
    HOLD = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j < 8)
        e = {2'b01, exp_norm(k + j)};
      else if (j < 12)
        e = 8'b1100_0000;
      else
        e = {2'b01, exp_norm(k + j - 4)};
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL hold j=%0d got %b want %b", j, obs, e);
      end
      if (j == 10) HOLD = 1'b0;
    end
    t = k + 16;
  endtask

  task automatic test_ce;
    int k;
    logic [7:0] e;
    align(4);
    k = t;
    CE = 1'b0;
    for (int j = 1; j <= 21; j++) begin
      step();
      e = (j <= 5) ? {2'b01, exp_norm(k + 1)}
                   : {2'b01, exp_norm(k + j - 5)};
      vecs++;
      if (obs !== e) begin
        errs++;
        $display("FAIL ce j=%0d got %b want %b", j, obs, e);
      end
      if (j == 5) CE = 1'b1;
    end
    t = k + 16;
  endtask

  task automatic test_abort_wait;
    align(2);
    WAITB = 1'b0;
    repeat (3) step();
    vecs++;
    if (obs !== 8'b0100_0000) begin
      errs++;
      $display("FAIL in_wait got %b want %b", obs, 8'b0100_0000);
    end
    #2 RESETB = 1'b0;
    #1;
    vecs++;
    if (obs !== 8'h00) begin
      errs++;
      $display("FAIL abort_wait got %b want %b", obs, 8'h00);
    end
    WAITB = 1'b1;
    repeat (2) step();
    vecs++;
    if (obs !== 8'h00) begin
      errs++;
      $display("FAIL held_rst got %b want %b", obs, 8'h00);
    end
    test_startup(1'b0);
  endtask

  task automatic test_abort_hold;
    align(0);
    HOLD = 1'b1;
    repeat (9) step();
    vecs++;
    if (obs !== 8'b1100_0000) begin
      errs++;
      $display("FAIL in_hold got %b want %b", obs, 8'b1100_0000);
    end
    #2 RESETB = 1'b0;
    #1;
    vecs++;
    if (obs !== 8'h00) begin
      errs++;
      $display("FAIL abort_hold got %b want %b", obs, 8'h00);
    end
    repeat (2) step();
    test_startup(1'b1);
  endtask

  initial begin
    test_reset();
    test_startup(1'b0);
    test_wait();
    test_hold();
    test_ce();
    test_abort_wait();
    test_abort_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
